// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_sync_thresh FIFO family.
package fifo_pkg;

    // Encoded as {read accepted, write accepted}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-2 depths index only valid entries.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for fifo_sync_thresh: synchronous write, registered read.
module fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            fifo_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= fifo_mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO with arbitrary depth, threshold flags and sticky error flags.
// Optional peak-occupancy output enabled by defining FIFO_WATERMARK_EN.
module fifo_sync_thresh
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
`ifdef FIFO_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] max_level
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    typedef logic [CNT_W-1:0] occ_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    occ_t             count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_ok, rd_ok;
    fifo_op_e         op;

    // A write at full is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_ok = rd_en & (count_q != '0);
        wr_ok = wr_en & ((count_q != CNT_W'(DEPTH)) | rd_en);
        op    = fifo_op_e'({rd_ok, wr_ok});

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), DEPTH));
        end
        if (rd_ok) begin
            rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), DEPTH));
        end

        count_d = count_q;
        case (op)
            OP_WR:   count_d = count_q + CNT_W'(1);
            OP_RD:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A fresh error on this edge takes priority over clr_err.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_en & ~wr_ok) begin
            ovf_d = 1'b1;
        end
        if (rd_en & (count_q == '0)) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign count        = count_q;
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

`ifdef FIFO_WATERMARK_EN
    occ_t max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (clr_err) begin
            max_d = '0;
        end else if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_level = max_q;
`endif

endmodule
